// File: rtl/audio_mixer_mac_if.sv
// audio_mixer_mac_if: sample/gain inputs and stereo result bus of the MAC mixer
interface audio_mixer_mac_if #(
  parameter int NUM_CH = 8,
  parameter int IN_W   = 16,
  parameter int VOL_W  = 8,
  parameter int OUT_W  = 16
);
  logic                    sample_stb;
  logic [NUM_CH*IN_W-1:0]  ch_data;
  logic [NUM_CH*VOL_W-1:0] gain_l;
  logic [NUM_CH*VOL_W-1:0] gain_r;
  logic                    mute;
  logic                    overrun_clr;
  logic                    busy;
  logic                    audio_valid;
  logic [OUT_W-1:0]        audio_l;
  logic [OUT_W-1:0]        audio_r;
  logic                    clip_l;
  logic                    clip_r;
  logic                    overrun;
  modport master (
    output sample_stb, ch_data, gain_l, gain_r, mute, overrun_clr,
    input  busy, audio_valid, audio_l, audio_r, clip_l, clip_r, overrun
  );
  modport slave (
    input  sample_stb, ch_data, gain_l, gain_r, mute, overrun_clr,
    output busy, audio_valid, audio_l, audio_r, clip_l, clip_r, overrun
  );
endinterface

// File: rtl/audio_mixer_mac.sv
// audio_mixer_mac: time-multiplexed per-channel L/R gain MAC with saturating stereo output
module audio_mixer_mac #(
  parameter int NUM_CH = 8,
  parameter int IN_W   = 16,
  parameter int VOL_W  = 8,
  parameter int OUT_W  = 16
) (
  input logic             clk,
  input logic             reset_n,
  audio_mixer_mac_if.slave bus
);
  localparam int IW = $clog2(NUM_CH);
  localparam int AW = IN_W + VOL_W + IW + 1;
  localparam int PW = IN_W + VOL_W + 1;
  localparam logic signed [AW-1:0] MAXV = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t                  state, state_nxt;
  logic [IW-1:0]           idx;
  logic [NUM_CH*IN_W-1:0]  ch_q;
  logic [NUM_CH*VOL_W-1:0] gl_q, gr_q;
  logic signed [AW-1:0]    acc_l, acc_r;
  logic signed [PW-1:0]    prod_l, prod_r;
  logic [OUT_W:0]          sat_l, sat_r;
  logic                    start;
  // {clip, value}: floor-shift back to unity scale, then clamp to the output range
  function automatic logic [OUT_W:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> (VOL_W - 1);
    return s > MAXV ? {1'b1, MAXV[OUT_W-1:0]} :
           s < MINV ? {1'b1, MINV[OUT_W-1:0]} : {1'b0, s[OUT_W-1:0]};
  endfunction
  // state register
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_nxt;
  // next state: one channel per cycle in ACC, single result cycle in DONE
  always_comb
    state_nxt = state == IDLE ? (bus.sample_stb ? ACC : IDLE) :
                state == ACC  ? (idx == IW'(NUM_CH - 1) ? DONE : ACC) : IDLE;
  // outputs decoded from state
  always_comb begin
    bus.busy = state != IDLE;
    start    = state == IDLE && bus.sample_stb;
  end
  // signed sample times zero-extended gain for the channel under idx
  always_comb begin
    prod_l = $signed(ch_q[idx*IN_W +: IN_W]) * $signed({1'b0, gl_q[idx*VOL_W +: VOL_W]});
    prod_r = $signed(ch_q[idx*IN_W +: IN_W]) * $signed({1'b0, gr_q[idx*VOL_W +: VOL_W]});
    sat_l  = sat(acc_l);
    sat_r  = sat(acc_r);
  end
  // snapshot, accumulate and publish the frame result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx             <= '0;
      ch_q            <= '0;
      gl_q            <= '0;
      gr_q            <= '0;
      acc_l           <= '0;
      acc_r           <= '0;
      bus.audio_valid <= 1'b0;
      bus.audio_l     <= '0;
      bus.audio_r     <= '0;
      bus.clip_l      <= 1'b0;
      bus.clip_r      <= 1'b0;
    end else begin
      bus.audio_valid <= 1'b0;
      if (start) begin
        ch_q  <= bus.ch_data;
        gl_q  <= bus.gain_l;
        gr_q  <= bus.gain_r;
        acc_l <= '0;
        acc_r <= '0;
        idx   <= '0;
      end
      if (state == ACC) begin
        acc_l <= acc_l + AW'(prod_l);
        acc_r <= acc_r + AW'(prod_r);
        idx   <= idx + IW'(1);
      end
      if (state == DONE) begin
        bus.audio_valid <= 1'b1;
        bus.audio_l     <= bus.mute ? '0 : sat_l[OUT_W-1:0];
        bus.audio_r     <= bus.mute ? '0 : sat_r[OUT_W-1:0];
        bus.clip_l      <= !bus.mute && sat_l[OUT_W];
        bus.clip_r      <= !bus.mute && sat_r[OUT_W];
      end
    end
  end
  // sticky overrun: a strobe during a frame; setting wins over clearing
  always_ff @(posedge clk)
    bus.overrun <= !reset_n ? 1'b0 : (bus.sample_stb && bus.busy) ? 1'b1 :
                   bus.overrun_clr ? 1'b0 : bus.overrun;
endmodule

// File: doc/audio_mixer_mac.md
Name: audio_mixer_mac

Overview:
Parametrised, time-multiplexed multiply-accumulate stereo mixer. It is the successor to the fixed-function mixer and sits between the sound sources (PSG, covox, SAA, GS, FM, ADC) and the DAC/I2S serializer. On each sample strobe it snapshots NUM_CH signed channel samples and applies independent per-channel left/right gains, one channel per clock. It outputs a saturated stereo sample with a valid pulse and clip flags.

Parameters:
NUM_CH, 8, number of input channels (2..32)
IN_W, 16, signed sample width per channel
VOL_W, 8, unsigned gain width; unity gain = 2^(VOL_W-1)
OUT_W, 16, signed output width

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
sample_stb  in  1  start-of-frame strobe, one cycle
ch_data  in  NUM_CH*IN_W  signed samples; channel k at bits [k*IN_W +: IN_W]
gain_l  in  NUM_CH*VOL_W  unsigned left gains, same packing as ch_data
gain_r  in  NUM_CH*VOL_W  unsigned right gains
mute  in  1  force output to zero
overrun_clr  in  1  clears overrun flag
busy  out  1  frame in progress
audio_valid  out  1  one-cycle pulse, new audio_l/audio_r
audio_l  out  OUT_W  signed left output, held between frames
audio_r  out  OUT_W  signed right output
clip_l  out  1  left saturated in last frame (updated with audio_valid)
clip_r  out  1  right saturated in last frame
overrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE, busy=0, audio_valid=0, audio_l=audio_r=0, clip_l=clip_r=0, overrun=0, accumulators and index=0. Reset mid-frame aborts the frame with no audio_valid; the outputs go to 0.
- States: IDLE, ACC, DONE.
- IDLE: on sample_stb=1 at edge E0, register all of ch_data, gain_l and gain_r. Clear both accumulators, set idx=0, go to ACC, busy=1 from E0.
- ACC: at edge E(k+1), k=0..NUM_CH-1, add ch[k]*gain_l[k] to acc_l and ch[k]*gain_r[k] to acc_r, then increment idx. The product is signed sample times zero-extended gain. After channel NUM_CH-1, go to DONE.
- DONE: at edge E(NUM_CH+1):
  - audio_x = sat(acc_x >>> (VOL_W-1)), using an arithmetic shift with floor rounding.
  - sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; clip_x=1 when clamping occurred, else 0.
  - If mute=1 at this edge: audio_l=audio_r=0 and clip flags=0. The frame still runs at full timing.
  - audio_valid=1 for exactly the cycle after E(NUM_CH+1). busy=0 and state IDLE from that edge.
- Latency: audio_valid is high in the cycle starting at edge E0+(NUM_CH+1). Minimum strobe period is NUM_CH+2 cycles.
- Accumulator width: IN_W+VOL_W+clog2(NUM_CH)+1. No internal overflow is possible for any inputs.
- sample_stb while busy=1 (ACC or DONE) is ignored: no restart and no effect on the current frame. overrun is set to 1.
- overrun stays set until overrun_clr=1 or reset. If overrun_clr and a new overrun occur on the same edge, set wins.
- Input changes after E0 have no effect on the current frame, because of the snapshot.
- Outputs hold their value between audio_valid pulses.

Test Plan:
- NUM_CH=8, ch0=16'h1000, gain_l0=gain_r0=8'h80, all other gains 0, stb: audio_valid exactly 9 cycles after the stb edge; audio_l=audio_r=16'h1000; clip flags 0.
- Pan: ch0=16'h2000, gain_l0=8'h80, gain_r0=8'h40, ch1=-16'sh1000, gain_l1=0, gain_r1=8'h80: audio_l=16'h2000, audio_r=16'h0000.
- Positive saturation: all 8 channels 16'h7FFF at gain 8'hFF: audio_l=audio_r=16'h7FFF, clip_l=clip_r=1. Negative saturation with 16'h8000 everywhere: 16'h8000, clip=1. The next frame with all-zero inputs clears the clip flags.
- Floor rounding: ch0=-16'sd1, gain 8'h40: output -1 (16'hFFFF), not 0.
- Overrun: a second stb 3 cycles after the first has no effect; the single audio_valid carries the first frame's values and overrun=1. Pulsing overrun_clr gives overrun=0. A stb exactly NUM_CH+2 cycles after the previous one is accepted and does not set overrun.
- Reset mid-frame: assert reset_n=0 at cycle 4 of ACC: no audio_valid, audio_l=audio_r=0, busy=0. A frame started after reset gives correct results. mute=1 during a frame: audio_valid still pulses with outputs 0.
